// File: rtl/dmem_responder.sv
// dmem_responder: single-port word memory behind a request/acknowledge handshake.
// A request is latched in IDLE, waits WAIT_CYCLES cycles in BUSY, then completes in ACK.
// Reads update the registered rdata. Writes update the storage array.
// A request with both read and write set completes with err and has no side effect.

module dmem_responder #(
   parameter int unsigned WAIT_CYCLES = 1,
   parameter int unsigned AW          = 8,
   parameter int unsigned DW          = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          mem_rd,
   input  logic          mem_wr,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata,
   output logic          ack,
   output logic          stall,
   output logic          err
);

   localparam int unsigned DEPTH    = 2 ** AW;
   localparam logic [3:0]  CNT_LOAD = 4'(WAIT_CYCLES);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_ACK  = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          rd_q, rd_d;
   logic          wr_q, wr_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata_q;

   // Storage is deliberately never reset; contents survive rst.
   logic [DW-1:0] mem [DEPTH];

   logic          req;
   logic          enter_ack;
   logic          acc_rd;
   logic          acc_wr;
   logic [AW-1:0] acc_addr;
   logic [DW-1:0] acc_wdata;
   logic          mem_we;
   logic          rdata_load;

   assign req = mem_rd | mem_wr;

   // Next-state logic; also selects which request copy governs the access on ACK entry.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rd_d      = rd_q;
      wr_d      = wr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      enter_ack = 1'b0;
      acc_rd    = rd_q;
      acc_wr    = wr_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;

      case (state_q)
         S_IDLE: begin
            if (req) begin
               rd_d    = mem_rd;
               wr_d    = mem_wr;
               addr_d  = addr;
               wdata_d = wdata;
               cnt_d   = CNT_LOAD;
               if (WAIT_CYCLES == 0) begin
                  // Zero wait states: the access happens on this very edge, so the
                  // live inputs (being latched right now) drive the memory.
                  state_d   = S_ACK;
                  enter_ack = 1'b1;
                  acc_rd    = mem_rd;
                  acc_wr    = mem_wr;
                  acc_addr  = addr;
                  acc_wdata = wdata;
               end else begin
                  state_d = S_BUSY;
               end
            end
         end

         S_BUSY: begin
            if (!req) begin
               // Initiator withdrew the request: abort with no side effects.
               state_d = S_IDLE;
               cnt_d   = 4'd0;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_d   = S_ACK;
                  enter_ack = 1'b1;
               end
            end
         end

         S_ACK: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase

      // Illegal rd&wr requests fall through both enables and only raise err in ACK.
      mem_we     = enter_ack & acc_wr & ~acc_rd;
      rdata_load = enter_ack & acc_rd & ~acc_wr;
   end

   // Control and latched-request registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // Read data register: loaded only when a legal read enters ACK.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (rdata_load) begin
         rdata_q <= mem[acc_addr];
      end
   end

   // Storage write port; reset blocks a write that would land on the same edge.
   always_ff @(posedge clk) begin
      if (!rst && mem_we) begin
         mem[acc_addr] <= acc_wdata;
      end
   end

   assign rdata = rdata_q;
   assign ack   = (state_q == S_ACK);
   assign err   = (state_q == S_ACK) & rd_q & wr_q;
   // Purely combinational so it keeps tracking the request even during reset.
   assign stall = req & ~ack;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: three instances with WAIT_CYCLES = 0, 1 and 3.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.

module tb_dmem_responder;

   logic        clk;
   logic        rst;
   logic        rd    [3];
   logic        wr    [3];
   logic [7:0]  ad    [3];
   logic [15:0] wd    [3];
   logic [15:0] rdata [3];
   logic        ack   [3];
   logic        stall [3];
   logic        err   [3];

   int checks;
   int errors;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Index 0: zero wait states.
   dmem_responder #(.WAIT_CYCLES(0), .AW(8), .DW(16)) u_w0 (
      .clk(clk), .rst(rst), .mem_rd(rd[0]), .mem_wr(wr[0]), .addr(ad[0]), .wdata(wd[0]),
      .rdata(rdata[0]), .ack(ack[0]), .stall(stall[0]), .err(err[0])
   );

   // Index 1: one wait state.
   dmem_responder #(.WAIT_CYCLES(1), .AW(8), .DW(16)) u_w1 (
      .clk(clk), .rst(rst), .mem_rd(rd[1]), .mem_wr(wr[1]), .addr(ad[1]), .wdata(wd[1]),
      .rdata(rdata[1]), .ack(ack[1]), .stall(stall[1]), .err(err[1])
   );

   // Index 2: three wait states.
   dmem_responder #(.WAIT_CYCLES(3), .AW(8), .DW(16)) u_w3 (
      .clk(clk), .rst(rst), .mem_rd(rd[2]), .mem_wr(wr[2]), .addr(ad[2]), .wdata(wd[2]),
      .rdata(rdata[2]), .ack(ack[2]), .stall(stall[2]), .err(err[2])
   );

   typedef struct packed {
      logic        rd;
      logic        wr;
      logic [7:0]  a;
      logic [15:0] d;
      logic        e_ack;
      logic        e_err;
      logic        e_stall;
      logic [15:0] e_rdata;
   } vec_t;

   vec_t tbl [20];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Start of a new cycle, just after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full handshake on instance i; checks ack arrives lat cycles after the request cycle.
   task automatic access(input int i, input logic r, input logic w, input logic [7:0] a,
                         input logic [15:0] d, input int lat, input string nm);
      int n;
      bit got;
      tick();
      rd[i] = r;
      wr[i] = w;
      ad[i] = a;
      wd[i] = d;
      got = 1'b0;
      n = 0;
      while (!got && n < 20) begin
         @(negedge clk);
         if (ack[i]) got = 1'b1;
         else begin
            n++;
            tick();
         end
      end
      chk({nm, " ack_seen"}, 32'(got), 32'd1);
      chk({nm, " latency"}, 32'(n), 32'(lat));
      tick();
      rd[i] = 1'b0;
      wr[i] = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rd[i] = 1'b0;
         wr[i] = 1'b0;
         ad[i] = 8'h00;
         wd[i] = 16'h0000;
      end

      // Table: one wait state. Write 0x12, write 0x05, read 0x12, illegal rd&wr on 0x05,
      // then read 0x05 to prove the illegal request left memory alone.
      tbl[0]  = '{1'b0, 1'b1, 8'h12, 16'hBEEF, 1'b0, 1'b0, 1'b1, 16'h0000};
      tbl[1]  = '{1'b0, 1'b1, 8'h12, 16'hBEEF, 1'b0, 1'b0, 1'b1, 16'h0000};
      tbl[2]  = '{1'b0, 1'b1, 8'h12, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'h0000};
      tbl[3]  = '{1'b0, 1'b0, 8'h12, 16'hBEEF, 1'b0, 1'b0, 1'b0, 16'h0000};
      tbl[4]  = '{1'b0, 1'b1, 8'h05, 16'h5555, 1'b0, 1'b0, 1'b1, 16'h0000};
      tbl[5]  = '{1'b0, 1'b1, 8'h05, 16'h5555, 1'b0, 1'b0, 1'b1, 16'h0000};
      tbl[6]  = '{1'b0, 1'b1, 8'h05, 16'h5555, 1'b1, 1'b0, 1'b0, 16'h0000};
      tbl[7]  = '{1'b0, 1'b0, 8'h05, 16'h5555, 1'b0, 1'b0, 1'b0, 16'h0000};
      tbl[8]  = '{1'b1, 1'b0, 8'h12, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000};
      tbl[9]  = '{1'b1, 1'b0, 8'h12, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000};
      tbl[10] = '{1'b1, 1'b0, 8'h12, 16'h0000, 1'b1, 1'b0, 1'b0, 16'hBEEF};
      tbl[11] = '{1'b0, 1'b0, 8'h12, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hBEEF};
      tbl[12] = '{1'b1, 1'b1, 8'h05, 16'hFFFF, 1'b0, 1'b0, 1'b1, 16'hBEEF};
      tbl[13] = '{1'b1, 1'b1, 8'h05, 16'hFFFF, 1'b0, 1'b0, 1'b1, 16'hBEEF};
      tbl[14] = '{1'b1, 1'b1, 8'h05, 16'hFFFF, 1'b1, 1'b1, 1'b0, 16'hBEEF};
      tbl[15] = '{1'b0, 1'b0, 8'h05, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'hBEEF};
      tbl[16] = '{1'b1, 1'b0, 8'h05, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hBEEF};
      tbl[17] = '{1'b1, 1'b0, 8'h05, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hBEEF};
      tbl[18] = '{1'b1, 1'b0, 8'h05, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h5555};
      tbl[19] = '{1'b0, 1'b0, 8'h05, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h5555};

      // Reset state of all instances.
      tick();
      tick();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("reset ack[%0d]", i), 32'(ack[i]), 32'd0);
         chk($sformatf("reset err[%0d]", i), 32'(err[i]), 32'd0);
         chk($sformatf("reset stall[%0d]", i), 32'(stall[i]), 32'd0);
         chk($sformatf("reset rdata[%0d]", i), 32'(rdata[i]), 32'd0);
      end
      // stall stays combinational while reset is held.
      tick();
      rd[0] = 1'b1;
      @(negedge clk);
      chk("stall in reset", 32'(stall[0]), 32'd1);
      chk("ack in reset", 32'(ack[0]), 32'd0);
      tick();
      rd[0] = 1'b0;
      rst = 1'b0;
      @(negedge clk);

      for (int k = 0; k < 20; k++) begin
         tick();
         rd[1] = tbl[k].rd;
         wr[1] = tbl[k].wr;
         ad[1] = tbl[k].a;
         wd[1] = tbl[k].d;
         @(negedge clk);
         chk($sformatf("tbl[%0d] ack", k), 32'(ack[1]), 32'(tbl[k].e_ack));
         chk($sformatf("tbl[%0d] err", k), 32'(err[1]), 32'(tbl[k].e_err));
         chk($sformatf("tbl[%0d] stall", k), 32'(stall[1]), 32'(tbl[k].e_stall));
         chk($sformatf("tbl[%0d] rdata", k), 32'(rdata[1]), 32'(tbl[k].e_rdata));
      end

      // Zero wait states: held read streams one access every second cycle.
      access(0, 1'b0, 1'b1, 8'h01, 16'h0011, 1, "w0 wr01");
      access(0, 1'b0, 1'b1, 8'h02, 16'h0022, 1, "w0 wr02");
      access(0, 1'b0, 1'b1, 8'h03, 16'h0033, 1, "w0 wr03");
      for (int k = 0; k < 3; k++) begin
         tick();
         rd[0] = 1'b1;
         ad[0] = 8'(k + 1);
         @(negedge clk);
         chk($sformatf("stream%0d req ack", k), 32'(ack[0]), 32'd0);
         chk($sformatf("stream%0d req stall", k), 32'(stall[0]), 32'd1);
         tick();
         @(negedge clk);
         chk($sformatf("stream%0d ack", k), 32'(ack[0]), 32'd1);
         chk($sformatf("stream%0d rdata", k), 32'(rdata[0]), 32'(16'h0011 * (k + 1)));
      end
      tick();
      rd[0] = 1'b0;
      @(negedge clk);
      chk("stream end ack", 32'(ack[0]), 32'd0);

      // Three wait states: write withdrawn mid-BUSY must abort with no write.
      access(2, 1'b0, 1'b1, 8'h40, 16'h0BAD, 4, "w3 wr40");
      tick();
      wr[2] = 1'b1;
      ad[2] = 8'h40;
      wd[2] = 16'h1234;
      @(negedge clk);
      chk("abort c0 stall", 32'(stall[2]), 32'd1);
      tick();
      @(negedge clk);
      chk("abort c1 stall", 32'(stall[2]), 32'd1);
      tick();
      wr[2] = 1'b0;
      @(negedge clk);
      for (int n = 0; n < 5; n++) begin
         chk($sformatf("abort no ack %0d", n), 32'(ack[2]), 32'd0);
         tick();
         @(negedge clk);
      end
      access(2, 1'b1, 1'b0, 8'h40, 16'h0000, 4, "w3 rd40");
      chk("abort mem40 kept", 32'(rdata[2]), 32'h0BAD);

      // Reset during BUSY of a write: no write, rdata cleared.
      access(2, 1'b0, 1'b1, 8'h07, 16'h7777, 4, "w3 wr07");
      tick();
      wr[2] = 1'b1;
      ad[2] = 8'h07;
      wd[2] = 16'hAAAA;
      @(negedge clk);
      tick();
      @(negedge clk);
      chk("rstbusy busy ack", 32'(ack[2]), 32'd0);
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("rstbusy stall", 32'(stall[2]), 32'd1);
      tick();
      rst = 1'b0;
      wr[2] = 1'b0;
      @(negedge clk);
      chk("rstbusy ack", 32'(ack[2]), 32'd0);
      chk("rstbusy err", 32'(err[2]), 32'd0);
      chk("rstbusy rdata", 32'(rdata[2]), 32'd0);
      for (int n = 0; n < 4; n++) begin
         tick();
         @(negedge clk);
         chk($sformatf("rstbusy no ack %0d", n), 32'(ack[2]), 32'd0);
      end
      access(2, 1'b1, 1'b0, 8'h07, 16'h0000, 4, "w3 rd07");
      chk("rstbusy mem07 kept", 32'(rdata[2]), 32'h7777);

      // One wait state: address change during BUSY is ignored.
      access(1, 1'b0, 1'b1, 8'h10, 16'h1010, 2, "w1 wr10");
      access(1, 1'b0, 1'b1, 8'h20, 16'h2020, 2, "w1 wr20");
      tick();
      rd[1] = 1'b1;
      ad[1] = 8'h10;
      @(negedge clk);
      chk("addrchg c0 stall", 32'(stall[1]), 32'd1);
      tick();
      ad[1] = 8'h20;
      @(negedge clk);
      chk("addrchg c1 ack", 32'(ack[1]), 32'd0);
      chk("addrchg c1 stall", 32'(stall[1]), 32'd1);
      tick();
      @(negedge clk);
      chk("addrchg c2 ack", 32'(ack[1]), 32'd1);
      chk("addrchg rdata", 32'(rdata[1]), 32'h1010);
      tick();
      rd[1] = 1'b0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
